dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single processor-to-data-memory port between the load queue (speculative loads) and the store queue (retired stores draining).
- Issues at most one memory command per cycle and tracks outstanding loads by memory tag.
- Returns load data, aligned to the requesting LSQ entry, one cycle after the memory tag returns.
- Sits between the LSQ and the top-level proc2mem/mem2proc bus, next to the load/store functional unit.

Parameters:
- XLEN, 32, architectural data width
- LSQ_IDX_LEN, 3, width of load-queue index
- MEM_DATA_W, 64, memory bus data width
- TAG_W, 4, memory tag width; tag 0 means "no tag / rejected"
- MAX_OUTSTANDING, 8, maximum loads in flight (must be ≤ 2^TAG_W − 1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  pipeline flush; kill all in-flight loads
- ld_req  in  1  load queue requests memory
- ld_addr  in  32  load byte address
- ld_size  in  2  MEM_SIZE of load (BYTE/HALF/WORD)
- ld_lq_idx  in  LSQ_IDX_LEN  load-queue entry of the request
- st_req  in  1  store queue has a retired store to drain
- st_addr  in  32  store byte address
- st_data  in  MEM_DATA_W  store data, already lane-aligned
- st_size  in  2  MEM_SIZE of store
- st_urgent  in  1  store queue nearly full
- ld_grant  out  1  load accepted by memory this cycle (combinational)
- st_grant  out  1  store accepted by memory this cycle (combinational)
- ld_done  out  1  load data valid (registered)
- ld_done_lq_idx  out  LSQ_IDX_LEN  entry receiving data
- ld_done_data  out  XLEN  load data shifted right by the byte offset; unextended
- proc2mem_command  out  2  BUS_NONE / BUS_LOAD / BUS_STORE
- proc2mem_addr  out  32  command address
- proc2mem_data  out  MEM_DATA_W  store data
- proc2mem_size  out  2  command size
- mem2proc_response  in  TAG_W  tag assigned this cycle; 0 = not accepted
- mem2proc_data  in  MEM_DATA_W  returned data
- mem2proc_tag  in  TAG_W  tag of returning data; 0 = none

Behaviour:
- Reset values: all registered outputs 0. Outstanding table cleared, count 0, round-robin pointer = load.
- Command selection (combinational):
  - No command when squash is high, or when neither request is eligible.
  - A load is eligible when ld_req is high and count < MAX_OUTSTANDING. A store is eligible when st_req is high.
  - When both are eligible, the round-robin pointer decides. The pointer flips to the other requester only when a grant actually occurs.
- Grant rules:
  - ld_grant = load selected && mem2proc_response != 0. st_grant is defined the same way for stores.
  - A rejected command (response 0) changes no state; the requester holds its request and the command is retried next cycle.
- Outstanding table: one entry per tag value 1..2^TAG_W−1, holding {busy, live, lq_idx, byte_off = ld_addr[2:0]}.
  - On ld_grant, the entry at index mem2proc_response is written with busy=1, live=1.
  - Writing a tag that is still busy is an assertion failure.
- Completion: when mem2proc_tag != 0 and that entry is busy, the entry is freed the same cycle.
  - If the entry is live, the next cycle drives ld_done=1, the stored lq_idx, and ld_done_data = (mem2proc_data >> (8*byte_off))[XLEN−1:0].
  - If the entry is not live, nothing is reported.
  - A tag that is not busy is ignored.
- Same tag freed and reissued in one cycle: the new write wins. The count is unchanged (+1 −1).
- Count: +1 on ld_grant, −1 on each freed busy entry. It saturates at neither end; over/underflow is an assertion failure.
- Squash: all entries get live=0 and stay busy until their tag returns. That cycle issues nothing and reports no ld_done (the registered ld_done is forced to 0 the next cycle). The count still drains on returns.
- Stores produce no completion; st_grant is the only acknowledgement.
- Reset mid-transaction: everything is cleared. Returns of stale tags are ignored because no entry is busy.

Optional Feature:
- DMEM_ARB_STORE_PRIO_EN defined: when st_urgent=1 and st_req=1, the store is selected regardless of the round-robin pointer. The pointer is still updated as for a normal store grant.
- Not defined: st_urgent is ignored; pure round-robin.

Test Plan:
- Reset, then load addr 0x104 size WORD lq_idx 2, memory responds tag 3, data returns tag 3 with mem2proc_data=0x11223344_55667788 → ld_grant=1 the issue cycle; next cycle after the return, ld_done=1, lq_idx=2, data=0x11223344.
- ld_req and st_req held with memory always accepting → grants alternate L,S,L,S; proc2mem_command alternates BUS_LOAD/BUS_STORE.
- Memory rejects for 3 cycles (response 0) then accepts tag 5 → no grant for 3 cycles, grant in cycle 4, count=1.
- Issue 8 loads with no returns → 9th ld_req gets no command; a pending store still issues; return of one tag frees a slot and the next load issues.
- Two loads in flight (tags 1,2), squash, then tags 1,2 return → no ld_done; count returns to 0; a load issued after the squash completes normally.
- With DMEM_ARB_STORE_PRIO_EN: pointer=load, st_urgent=1, both requesting → store granted; without the macro → load granted.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of LSQ-side and memory-bus signals for dmem_port_arbiter.
// The slave modport is the arbiter's view; master is the LSQ/memory environment.
interface dmem_port_arbiter_if #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned LSQ_IDX_LEN = 3,
   parameter int unsigned MEM_DATA_W  = 64,
   parameter int unsigned TAG_W       = 4
);
   logic                   squash;
   logic                   ld_req;
   logic [31:0]            ld_addr;
   logic [1:0]             ld_size;
   logic [LSQ_IDX_LEN-1:0] ld_lq_idx;
   logic                   st_req;
   logic [31:0]            st_addr;
   logic [MEM_DATA_W-1:0]  st_data;
   logic [1:0]             st_size;
   logic                   st_urgent;
   logic                   ld_grant;
   logic                   st_grant;
   logic                   ld_done;
   logic [LSQ_IDX_LEN-1:0] ld_done_lq_idx;
   logic [XLEN-1:0]        ld_done_data;
   logic [1:0]             proc2mem_command;
   logic [31:0]            proc2mem_addr;
   logic [MEM_DATA_W-1:0]  proc2mem_data;
   logic [1:0]             proc2mem_size;
   logic [TAG_W-1:0]       mem2proc_response;
   logic [MEM_DATA_W-1:0]  mem2proc_data;
   logic [TAG_W-1:0]       mem2proc_tag;

   modport slave (
      input  squash, ld_req, ld_addr, ld_size, ld_lq_idx,
      input  st_req, st_addr, st_data, st_size, st_urgent,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output ld_grant, st_grant, ld_done, ld_done_lq_idx, ld_done_data,
      output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
   );

   modport master (
      output squash, ld_req, ld_addr, ld_size, ld_lq_idx,
      output st_req, st_addr, st_data, st_size, st_urgent,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  ld_grant, st_grant, ld_done, ld_done_lq_idx, ld_done_data,
      input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the data-memory port between load and store queues.
// Define DMEM_ARB_STORE_PRIO_EN to let an urgent store override the round-robin pointer.
module dmem_port_arbiter #(
   parameter int unsigned XLEN            = 32,
   parameter int unsigned LSQ_IDX_LEN     = 3,
   parameter int unsigned MEM_DATA_W      = 64,
   parameter int unsigned TAG_W           = 4,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input logic             clock,
   input logic             reset,
   dmem_port_arbiter_if.slave bus
);
   localparam int unsigned NumTags = 2 ** TAG_W;
   localparam int unsigned CntW    = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {BusNone = 2'd0, BusLoad = 2'd1, BusStore = 2'd2} bus_cmd_e;
   typedef enum logic {PtrLoad = 1'b0, PtrStore = 1'b1} rr_ptr_e;

   rr_ptr_e                ptr_q, ptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic                   busy_q [NumTags];
   logic                   live_q [NumTags];
   logic [LSQ_IDX_LEN-1:0] idx_q  [NumTags];
   logic [2:0]             off_q  [NumTags];
   logic                   done_q, done_d;
   logic [LSQ_IDX_LEN-1:0] done_idx_q, done_idx_d;
   logic [XLEN-1:0]        done_data_q, done_data_d;

   logic                   ld_elig, st_elig, sel_ld, sel_st;
   logic                   ld_grant, st_grant, ret_hit;
   logic [MEM_DATA_W-1:0]  shifted;

`ifndef DMEM_ARB_STORE_PRIO_EN
   logic unused_st_urgent;
   assign unused_st_urgent = bus.st_urgent;
`endif

   always_comb begin
      ld_elig = bus.ld_req && (count_q < CntW'(MAX_OUTSTANDING));
      st_elig = bus.st_req;
      sel_ld  = 1'b0;
      sel_st  = 1'b0;
      if (!bus.squash) begin
         if (ld_elig && st_elig) begin
            if (ptr_q == PtrLoad) sel_ld = 1'b1;
            else                  sel_st = 1'b1;
         end else begin
            sel_ld = ld_elig;
            sel_st = st_elig;
         end
`ifdef DMEM_ARB_STORE_PRIO_EN
         if (bus.st_urgent && st_elig) begin
            sel_ld = 1'b0;
            sel_st = 1'b1;
         end
`endif
      end
      ld_grant = sel_ld && (bus.mem2proc_response != '0);
      st_grant = sel_st && (bus.mem2proc_response != '0);
   end

   assign bus.ld_grant = ld_grant;
   assign bus.st_grant = st_grant;

   always_comb begin
      bus.proc2mem_command = BusNone;
      bus.proc2mem_addr    = '0;
      bus.proc2mem_data    = '0;
      bus.proc2mem_size    = '0;
      if (sel_ld) begin
         bus.proc2mem_command = BusLoad;
         bus.proc2mem_addr    = bus.ld_addr;
         bus.proc2mem_size    = bus.ld_size;
      end else if (sel_st) begin
         bus.proc2mem_command = BusStore;
         bus.proc2mem_addr    = bus.st_addr;
         bus.proc2mem_data    = bus.st_data;
         bus.proc2mem_size    = bus.st_size;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (ld_grant)      ptr_d = PtrStore;
      else if (st_grant) ptr_d = PtrLoad;
   end

   always_ff @(posedge clock) begin
      if (reset) ptr_q <= PtrLoad;
      else       ptr_q <= ptr_d;
   end

   // A squashed load still occupies its tag; it just reports nothing on return.
   always_comb begin
      ret_hit     = (bus.mem2proc_tag != '0) && busy_q[bus.mem2proc_tag];
      shifted     = bus.mem2proc_data >> {off_q[bus.mem2proc_tag], 3'b000};
      done_d      = ret_hit && live_q[bus.mem2proc_tag] && !bus.squash;
      done_idx_d  = idx_q[bus.mem2proc_tag];
      done_data_d = shifted[XLEN-1:0];
      count_d     = count_q + CntW'(ld_grant) - CntW'(ret_hit);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NumTags; i++) begin
            busy_q[i] <= 1'b0;
            live_q[i] <= 1'b0;
            idx_q[i]  <= '0;
            off_q[i]  <= '0;
         end
         count_q     <= '0;
         done_q      <= 1'b0;
         done_idx_q  <= '0;
         done_data_q <= '0;
      end else begin
         if (ret_hit) busy_q[bus.mem2proc_tag] <= 1'b0;
         if (bus.squash) begin
            for (int i = 0; i < NumTags; i++) live_q[i] <= 1'b0;
         end
         // Issued after the free so a same-cycle reuse of the tag wins.
         if (ld_grant) begin
            busy_q[bus.mem2proc_response] <= 1'b1;
            live_q[bus.mem2proc_response] <= 1'b1;
            idx_q[bus.mem2proc_response]  <= bus.ld_lq_idx;
            off_q[bus.mem2proc_response]  <= bus.ld_addr[2:0];
         end
         count_q     <= count_d;
         done_q      <= done_d;
         done_idx_q  <= done_idx_d;
         done_data_q <= done_data_d;
      end
   end

   assign bus.ld_done        = done_q;
   assign bus.ld_done_lq_idx = done_idx_q;
   assign bus.ld_done_data   = done_data_q;

   a_no_busy_reuse: assert property (@(posedge clock) disable iff (reset)
      !(ld_grant && busy_q[bus.mem2proc_response] &&
        !(ret_hit && (bus.mem2proc_tag == bus.mem2proc_response))));
   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(ld_grant && !ret_hit && (count_q == CntW'(MAX_OUTSTANDING))));
   a_no_underflow: assert property (@(posedge clock) disable iff (reset)
      !(ret_hit && !ld_grant && (count_q == '0)));
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter.
module tb_dmem_port_arbiter;
   logic clock;
   logic reset;
   int   pass_cnt;
   int   total_cnt;

   dmem_port_arbiter_if #(
      .XLEN(32), .LSQ_IDX_LEN(3), .MEM_DATA_W(64), .TAG_W(4)
   ) bus ();

   dmem_port_arbiter #(
      .XLEN(32), .LSQ_IDX_LEN(3), .MEM_DATA_W(64), .TAG_W(4), .MAX_OUTSTANDING(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus.squash = 0; bus.ld_req = 0; bus.ld_addr = 0; bus.ld_size = 0; bus.ld_lq_idx = 0;
      bus.st_req = 0; bus.st_addr = 0; bus.st_data = 0; bus.st_size = 0; bus.st_urgent = 0;
      bus.mem2proc_response = 0; bus.mem2proc_data = 0; bus.mem2proc_tag = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total_cnt++;
      if (bus.ld_done !== 1'b0 || bus.ld_done_lq_idx !== 3'd0 || bus.ld_done_data !== 32'd0)
         $display("FAIL reset_outputs: done=%b idx=%0d data=%h, want 0/0/0",
                  bus.ld_done, bus.ld_done_lq_idx, bus.ld_done_data);
      else pass_cnt++;
      total_cnt++;
      if (dut.count_q !== 4'd0) $display("FAIL reset_count: got %0d want 0", dut.count_q);
      else pass_cnt++;
      total_cnt++;
      if (bus.proc2mem_command !== 2'd0)
         $display("FAIL reset_cmd: got %0d want 0", bus.proc2mem_command);
      else pass_cnt++;
   endtask

   task automatic test_single_load();
      do_reset();
      bus.ld_req = 1; bus.ld_addr = 32'h104; bus.ld_size = 2'd2; bus.ld_lq_idx = 3'd2;
      bus.mem2proc_response = 4'd3;
      #1;
      total_cnt++;
      if (bus.ld_grant !== 1'b1 || bus.proc2mem_command !== 2'd1 ||
          bus.proc2mem_addr !== 32'h104)
         $display("FAIL single_issue: grant=%b cmd=%0d addr=%h, want 1/1/104",
                  bus.ld_grant, bus.proc2mem_command, bus.proc2mem_addr);
      else pass_cnt++;
      cyc();
      bus.ld_req = 0; bus.mem2proc_response = 0;
      bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'h11223344_55667788;
      #1;
      total_cnt++;
      if (bus.ld_done !== 1'b0) $display("FAIL single_early_done: got %b want 0", bus.ld_done);
      else pass_cnt++;
      cyc();
      bus.mem2proc_tag = 0;
      #1;
      total_cnt++;
      if (bus.ld_done !== 1'b1 || bus.ld_done_lq_idx !== 3'd2 ||
          bus.ld_done_data !== 32'h11223344)
         $display("FAIL single_done: done=%b idx=%0d data=%h, want 1/2/11223344",
                  bus.ld_done, bus.ld_done_lq_idx, bus.ld_done_data);
      else pass_cnt++;
      total_cnt++;
      if (dut.count_q !== 4'd0) $display("FAIL single_count: got %0d want 0", dut.count_q);
      else pass_cnt++;
      cyc();
   endtask

   task automatic test_round_robin();
      logic want_ld;
      do_reset();
      bus.ld_req = 1; bus.ld_addr = 32'h40; bus.st_req = 1; bus.st_addr = 32'h200;
      bus.st_data = 64'hDEAD_BEEF_0000_0001;
      for (int i = 0; i < 4; i++) begin
         bus.mem2proc_response = 4'(i + 1);
         want_ld = (i % 2 == 0);
         #1;
         total_cnt++;
         if (bus.ld_grant !== want_ld || bus.st_grant !== !want_ld ||
             bus.proc2mem_command !== (want_ld ? 2'd1 : 2'd2))
            $display("FAIL rr_cycle%0d: ld=%b st=%b cmd=%0d, want ld=%b st=%b",
                     i, bus.ld_grant, bus.st_grant, bus.proc2mem_command, want_ld, !want_ld);
         else pass_cnt++;
         cyc();
      end
      clear_inputs();
   endtask

   task automatic test_reject();
      do_reset();
      bus.ld_req = 1; bus.ld_addr = 32'h80; bus.ld_lq_idx = 3'd1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++;
         if (bus.ld_grant !== 1'b0 || bus.proc2mem_command !== 2'd1)
            $display("FAIL reject_cycle%0d: grant=%b cmd=%0d, want 0/1",
                     i, bus.ld_grant, bus.proc2mem_command);
         else pass_cnt++;
         cyc();
      end
      bus.mem2proc_response = 4'd5;
      #1;
      total_cnt++;
      if (bus.ld_grant !== 1'b1) $display("FAIL reject_accept: got %b want 1", bus.ld_grant);
      else pass_cnt++;
      cyc();
      clear_inputs();
      #1;
      total_cnt++;
      if (dut.count_q !== 4'd1) $display("FAIL reject_count: got %0d want 1", dut.count_q);
      else pass_cnt++;
   endtask

   task automatic test_full();
      do_reset();
      bus.ld_req = 1;
      for (int i = 0; i < 8; i++) begin
         bus.ld_addr = 32'(i * 8); bus.ld_lq_idx = 3'(i); bus.mem2proc_response = 4'(i + 1);
         #1;
         total_cnt++;
         if (bus.ld_grant !== 1'b1) $display("FAIL full_fill%0d: got %b want 1", i, bus.ld_grant);
         else pass_cnt++;
         cyc();
      end
      bus.mem2proc_response = 4'd9;
      #1;
      total_cnt++;
      if (bus.proc2mem_command !== 2'd0 || bus.ld_grant !== 1'b0)
         $display("FAIL full_block: cmd=%0d grant=%b, want 0/0",
                  bus.proc2mem_command, bus.ld_grant);
      else pass_cnt++;
      bus.st_req = 1; bus.st_addr = 32'h300;
      #1;
      total_cnt++;
      if (bus.st_grant !== 1'b1 || bus.proc2mem_command !== 2'd2)
         $display("FAIL full_store: st=%b cmd=%0d, want 1/2", bus.st_grant, bus.proc2mem_command);
      else pass_cnt++;
      cyc();
      bus.st_req = 0; bus.mem2proc_response = 0;
      bus.mem2proc_tag = 4'd4; bus.mem2proc_data = 64'hAABBCCDD_01234567;
      #1;
      total_cnt++;
      if (bus.proc2mem_command !== 2'd0)
         $display("FAIL full_still_blocked: cmd=%0d want 0", bus.proc2mem_command);
      else pass_cnt++;
      cyc();
      bus.mem2proc_tag = 0; bus.mem2proc_response = 4'd4;
      bus.ld_addr = 32'h500; bus.ld_lq_idx = 3'd7;
      #1;
      total_cnt++;
      if (bus.ld_grant !== 1'b1) $display("FAIL full_reissue: got %b want 1", bus.ld_grant);
      else pass_cnt++;
      total_cnt++;
      if (bus.ld_done !== 1'b1 || bus.ld_done_lq_idx !== 3'd3 ||
          bus.ld_done_data !== 32'h01234567)
         $display("FAIL full_done: done=%b idx=%0d data=%h, want 1/3/01234567",
                  bus.ld_done, bus.ld_done_lq_idx, bus.ld_done_data);
      else pass_cnt++;
      cyc();
      clear_inputs();
   endtask

   task automatic test_squash();
      do_reset();
      bus.ld_req = 1; bus.ld_lq_idx = 3'd5; bus.mem2proc_response = 4'd1;
      cyc();
      bus.ld_lq_idx = 3'd6; bus.mem2proc_response = 4'd2;
      cyc();
      bus.squash = 1; bus.mem2proc_response = 4'd7;
      bus.mem2proc_tag = 4'd1; bus.mem2proc_data = 64'h1;
      #1;
      total_cnt++;
      if (bus.proc2mem_command !== 2'd0 || bus.ld_grant !== 1'b0)
         $display("FAIL squash_issue: cmd=%0d grant=%b, want 0/0",
                  bus.proc2mem_command, bus.ld_grant);
      else pass_cnt++;
      cyc();
      bus.squash = 0; bus.ld_req = 0; bus.mem2proc_response = 0; bus.mem2proc_tag = 4'd2;
      #1;
      total_cnt++;
      if (bus.ld_done !== 1'b0) $display("FAIL squash_done_t1: got %b want 0", bus.ld_done);
      else pass_cnt++;
      cyc();
      bus.mem2proc_tag = 0;
      #1;
      total_cnt++;
      if (bus.ld_done !== 1'b0) $display("FAIL squash_done_t2: got %b want 0", bus.ld_done);
      else pass_cnt++;
      total_cnt++;
      if (dut.count_q !== 4'd0) $display("FAIL squash_count: got %0d want 0", dut.count_q);
      else pass_cnt++;
      bus.ld_req = 1; bus.ld_addr = 32'h3; bus.ld_lq_idx = 3'd4; bus.mem2proc_response = 4'd1;
      #1;
      total_cnt++;
      if (bus.ld_grant !== 1'b1) $display("FAIL squash_reissue: got %b want 1", bus.ld_grant);
      else pass_cnt++;
      cyc();
      bus.ld_req = 0; bus.mem2proc_response = 0;
      bus.mem2proc_tag = 4'd1; bus.mem2proc_data = 64'h11223344_55667788;
      cyc();
      bus.mem2proc_tag = 0;
      #1;
      total_cnt++;
      if (bus.ld_done !== 1'b1 || bus.ld_done_lq_idx !== 3'd4 ||
          bus.ld_done_data !== 32'h22334455)
         $display("FAIL squash_after: done=%b idx=%0d data=%h, want 1/4/22334455",
                  bus.ld_done, bus.ld_done_lq_idx, bus.ld_done_data);
      else pass_cnt++;
      cyc();
   endtask

   task automatic test_store_prio();
      logic want_st;
`ifdef DMEM_ARB_STORE_PRIO_EN
      want_st = 1'b1;
`else
      want_st = 1'b0;
`endif
      do_reset();
      bus.ld_req = 1; bus.st_req = 1; bus.st_urgent = 1; bus.mem2proc_response = 4'd1;
      #1;
      total_cnt++;
      if (bus.st_grant !== want_st || bus.ld_grant !== !want_st)
         $display("FAIL store_prio: st=%b ld=%b, want st=%b ld=%b",
                  bus.st_grant, bus.ld_grant, want_st, !want_st);
      else pass_cnt++;
      cyc();
      clear_inputs();
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      reset     = 1'b1;
      clear_inputs();
      test_reset();
      test_single_load();
      test_round_robin();
      test_reject();
      test_full();
      test_squash();
      test_store_prio();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
